// File: rtl/acc_result_packer.sv
// Packs four consecutive fp32 accumulator sums into one 128-bit word and queues the
// words in a first-word-fall-through FIFO with a valid/ready output and overflow tracking.
module acc_result_packer #(
  parameter int RESULT_NUM = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stage_start,
  input  logic                         input_atvalid,
  input  logic [127:0]                 input_atdata,
  output logic                         output_atvalid,
  output logic [127:0]                 output_atdata,
  input  logic                         output_atready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         stage_done,
  output logic                         overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RESULT_NUM + 1);
  localparam logic [CW-1:0] RES_MAX    = CW'(RESULT_NUM);
  localparam logic [CW-1:0] RES_LAST   = CW'(RESULT_NUM - 1);
  localparam logic [PW:0]   LEVEL_FULL = (PW+1)'(FIFO_DEPTH);

  logic [31:0]    lane_reg [3];
  logic [1:0]     lane_ptr_reg;
  logic [CW-1:0]  res_cnt_reg;
  logic           stage_start_d_reg;
  logic           stage_done_reg;
  logic           overflow_reg;
  logic [PW-1:0]  wr_ptr_reg;
  logic [PW-1:0]  rd_ptr_reg;
  logic [PW:0]    level_reg;
  logic [127:0]   mem [FIFO_DEPTH];

  logic [31:0]    sum;
  logic [127:0]   push_word;
  logic           accept, beat_drop, last_beat, push_beat, flush, push;
  logic           pop, full, push_ok, push_drop;
  logic           unused_upper;

  // Only lane 0 of the replicated input carries information.
  assign sum          = input_atdata[31:0];
  assign unused_upper = ^input_atdata[127:32];

  always_comb begin
    accept    = stage_start && input_atvalid && (res_cnt_reg < RES_MAX);
    beat_drop = stage_start && input_atvalid && (res_cnt_reg == RES_MAX);
    last_beat = accept && (res_cnt_reg == RES_LAST);
    push_beat = accept && ((lane_ptr_reg == 2'd3) || last_beat);
    flush     = !stage_start && (lane_ptr_reg != 2'd0);
    push      = push_beat || flush;
    pop       = (level_reg != '0) && output_atready;
    full      = (level_reg == LEVEL_FULL);
    push_ok   = push && (!full || pop);
    push_drop = push && full && !pop;
  end

  // Word assembly: stored lanes below the pointer, the incoming sum at it, zeros above.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      logic [31:0] stored;
      if (gi < 3) begin : g_st
        assign stored = lane_reg[gi];
      end else begin : g_nost
        assign stored = 32'h0;
      end
      assign push_word[32*gi +: 32] = (lane_ptr_reg > 2'(gi)) ? stored :
                                      (push_beat && lane_ptr_reg == 2'(gi)) ? sum : 32'h0;
    end

    for (gi = 0; gi < 3; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_reg[gi] <= 32'h0;
        end else if (push) begin
          lane_reg[gi] <= 32'h0;
        end else if (accept && lane_ptr_reg == 2'(gi)) begin
          lane_reg[gi] <= sum;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_ptr_reg      <= 2'd0;
      res_cnt_reg       <= '0;
      stage_start_d_reg <= 1'b0;
      stage_done_reg    <= 1'b0;
      overflow_reg      <= 1'b0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      level_reg         <= '0;
    end else begin
      stage_start_d_reg <= stage_start;
      stage_done_reg    <= push_beat && last_beat;

      if (push)        lane_ptr_reg <= 2'd0;
      else if (accept) lane_ptr_reg <= lane_ptr_reg + 2'd1;

      if (!stage_start) res_cnt_reg <= '0;
      else if (accept)  res_cnt_reg <= res_cnt_reg + CW'(1);

      // A new drop on the stage's first edge wins over the clear.
      if (beat_drop || push_drop)               overflow_reg <= 1'b1;
      else if (stage_start && !stage_start_d_reg) overflow_reg <= 1'b0;

      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);

      if (push_ok && !pop)      level_reg <= level_reg + (PW+1)'(1);
      else if (!push_ok && pop) level_reg <= level_reg - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_word;
  end

  assign output_atvalid = (level_reg != '0);
  assign output_atdata  = output_atvalid ? mem[rd_ptr_reg] : 128'h0;
  assign fifo_level     = level_reg;
  assign stage_done     = stage_done_reg;
  assign overflow       = overflow_reg;

endmodule

// File: tb/tb_acc_result_packer.sv
// Directed bench for acc_result_packer: three instances (4, 6 and 64 sums per stage)
// share one stimulus stream; each scenario checks only the instance it targets.
module tb_acc_result_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stage_start = 1'b0;
  logic         input_atvalid = 1'b0;
  logic [127:0] input_atdata = '0;
  logic         output_atready = 1'b0;

  logic         a_valid, b_valid, c_valid;
  logic [127:0] a_data, b_data, c_data;
  logic [2:0]   a_level, b_level, c_level;
  logic         a_done, b_done, c_done;
  logic         a_ovf, b_ovf, c_ovf;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  acc_result_packer #(.RESULT_NUM(4), .FIFO_DEPTH(4)) ua (
    .clk(clk), .rst_n(rst_n), .stage_start(stage_start),
    .input_atvalid(input_atvalid), .input_atdata(input_atdata),
    .output_atvalid(a_valid), .output_atdata(a_data), .output_atready(output_atready),
    .fifo_level(a_level), .stage_done(a_done), .overflow(a_ovf));

  acc_result_packer #(.RESULT_NUM(6), .FIFO_DEPTH(4)) ub (
    .clk(clk), .rst_n(rst_n), .stage_start(stage_start),
    .input_atvalid(input_atvalid), .input_atdata(input_atdata),
    .output_atvalid(b_valid), .output_atdata(b_data), .output_atready(output_atready),
    .fifo_level(b_level), .stage_done(b_done), .overflow(b_ovf));

  acc_result_packer #(.RESULT_NUM(64), .FIFO_DEPTH(4)) uc (
    .clk(clk), .rst_n(rst_n), .stage_start(stage_start),
    .input_atvalid(input_atvalid), .input_atdata(input_atdata),
    .output_atvalid(c_valid), .output_atdata(c_data), .output_atready(output_atready),
    .fifo_level(c_level), .stage_done(c_done), .overflow(c_ovf));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] v);
    input_atvalid = 1'b1;
    input_atdata  = {4{v}};
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stage_start = 1'b0;
    input_atvalid = 1'b0;
    input_atdata = '0;
    output_atready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Sums used by the 64-sum instance: 0x100 + index; word k holds sums 4k..4k+3.
  function automatic logic [127:0] cword(input int k);
    logic [31:0] b;
    b = 32'h100 + 32'(4 * k);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  initial begin
    // ---------------- reset state + basic pack (4 sums per stage) ----------------
    do_reset();
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_data", a_data, 128'h0);
    chk("rst_level", a_level, 3'd0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_ovf", a_ovf, 1'b0);
    stage_start = 1'b1;
    output_atready = 1'b1;
    send(32'h3F800000);
    send(32'h40000000);
    send(32'h40400000);
    chk("basic_valid_early", a_valid, 1'b0);
    send(32'h40800000);
    chk("basic_valid", a_valid, 1'b1);
    chk("basic_data", a_data, {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000});
    chk("basic_level", a_level, 3'd1);
    chk("basic_done", a_done, 1'b1);
    input_atvalid = 1'b0;
    tick();
    chk("basic_done_pulse", a_done, 1'b0);
    chk("basic_drained", a_valid, 1'b0);

    // ---------------- padding (6 sums per stage) ----------------
    do_reset();
    stage_start = 1'b1;
    send(32'h11); send(32'h22); send(32'h33); send(32'h44);
    chk("pad_level1", b_level, 3'd1);
    chk("pad_word1", b_data, {32'h44, 32'h33, 32'h22, 32'h11});
    send(32'h55);
    chk("pad_done_early", b_done, 1'b0);
    send(32'h66);
    chk("pad_level2", b_level, 3'd2);
    chk("pad_done", b_done, 1'b1);
    chk("pad_head_stable", b_data, {32'h44, 32'h33, 32'h22, 32'h11});
    send(32'h77);
    chk("pad_ovf", b_ovf, 1'b1);
    chk("pad_done_off", b_done, 1'b0);
    chk("pad_level_kept", b_level, 3'd2);
    input_atvalid = 1'b0;
    output_atready = 1'b1;
    tick();
    chk("pad_word2", b_data, {32'h0, 32'h0, 32'h66, 32'h55});
    tick();
    chk("pad_empty", b_valid, 1'b0);

    // ---------------- backpressure (64 sums per stage) ----------------
    do_reset();
    stage_start = 1'b1;
    for (int i = 0; i < 16; i++) send(32'h100 + 32'(i));
    chk("bp_full", c_level, 3'd4);
    chk("bp_no_ovf", c_ovf, 1'b0);
    for (int i = 16; i < 20; i++) send(32'h100 + 32'(i));
    chk("bp_level_kept", c_level, 3'd4);
    chk("bp_ovf", c_ovf, 1'b1);
    input_atvalid = 1'b0;
    output_atready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_drain%0d", k), c_data, cword(k));
      tick();
    end
    chk("bp_empty", c_valid, 1'b0);

    // ---------------- full FIFO with simultaneous push and pop ----------------
    do_reset();
    stage_start = 1'b1;
    for (int i = 0; i < 19; i++) send(32'h100 + 32'(i));
    chk("sim_full", c_level, 3'd4);
    output_atready = 1'b1;
    send(32'h100 + 32'd19);
    chk("sim_level", c_level, 3'd4);
    chk("sim_no_ovf", c_ovf, 1'b0);
    input_atvalid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("sim_order%0d", k), c_data, cword(k));
      tick();
    end
    chk("sim_empty", c_valid, 1'b0);

    // ---------------- abort flush ----------------
    do_reset();
    stage_start = 1'b1;
    send(32'hA1);
    send(32'hA2);
    stage_start = 1'b0;
    send(32'hDEAD);
    chk("abort_level", a_level, 3'd1);
    chk("abort_word", a_data, {32'h0, 32'h0, 32'hA2, 32'hA1});
    chk("abort_no_done", a_done, 1'b0);
    chk("abort_no_ovf", a_ovf, 1'b0);
    input_atvalid = 1'b0;
    tick();
    chk("abort_level_hold", a_level, 3'd1);
    chk("abort_no_done2", a_done, 1'b0);
    stage_start = 1'b1;
    send(32'hB1); send(32'hB2); send(32'hB3); send(32'hB4);
    chk("restart_level", a_level, 3'd2);
    chk("restart_done", a_done, 1'b1);
    input_atvalid = 1'b0;
    output_atready = 1'b1;
    chk("restart_head_a", a_data, {32'h0, 32'h0, 32'hA2, 32'hA1});
    tick();
    chk("restart_head_b", a_data, {32'hB4, 32'hB3, 32'hB2, 32'hB1});
    tick();
    chk("restart_empty", a_valid, 1'b0);

    // ---------------- asynchronous reset mid-stage ----------------
    do_reset();
    stage_start = 1'b1;
    for (int i = 0; i < 14; i++) send(32'h100 + 32'(i));
    chk("areset_pre_level", c_level, 3'd3);
    input_atvalid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", c_valid, 1'b0);
    chk("areset_data", c_data, 128'h0);
    chk("areset_level", c_level, 3'd0);
    chk("areset_ovf", c_ovf, 1'b0);
    chk("areset_done", c_done, 1'b0);
    #1;
    rst_n = 1'b1;
    send(32'hD1); send(32'hD2); send(32'hD3); send(32'hD4);
    chk("areset_clean_level", c_level, 3'd1);
    chk("areset_clean_word", c_data, {32'hD4, 32'hD3, 32'hD2, 32'hD1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
